mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: decodes loads/stores from EX/MEM, runs a single-outstanding
// data-memory handshake with an ack timeout, and registers the MEM/WB result.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  Rd_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic [2:0]  funct3_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        valid_out,
    output logic        reg_write_out,
    output logic        mem_fault_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  Rd_out
);

    // state  | meaning
    // IDLE   | accepting EX/MEM; non-memory ops and faults retire in one edge
    // ACCESS | request outstanding on dmem, waiting for ack or timeout

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  f3_q, f3_d;
    logic        rw_q, rw_d;
    logic        load_q, load_d;

    logic        valid_q, valid_d;
    logic        rw_out_q, rw_out_d;
    logic        fault_q, fault_d;
    logic [31:0] wb_q, wb_d;
    logic [4:0]  rd_out_q, rd_out_d;

    logic        is_mem;
    logic        fault_c;
    logic        stall_c;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign is_mem = mem_read_in | mem_write_in;

    // Misalignment, illegal size codes and read+write together all retire as faults
    always_comb begin
        fault_c = 1'b0;
        if (mem_read_in && mem_write_in) begin
            fault_c = 1'b1;
        end else if (mem_read_in) begin
            case (funct3_in)
                3'b000, 3'b100: fault_c = 1'b0;
                3'b001, 3'b101: fault_c = alu_result_in[0];
                3'b010:         fault_c = |alu_result_in[1:0];
                default:        fault_c = 1'b1;
            endcase
        end else if (mem_write_in) begin
            case (funct3_in)
                3'b000:  fault_c = 1'b0;
                3'b001:  fault_c = alu_result_in[0];
                3'b010:  fault_c = |alu_result_in[1:0];
                default: fault_c = 1'b1;
            endcase
        end
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                st_be    = 4'b0001 << alu_result_in[1:0];
                st_wdata = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                st_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data_in[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = store_data_in;
            end
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (addr_q[1:0])
            2'b00: ld_byte = dmem_rdata[7:0];
            2'b01: ld_byte = dmem_rdata[15:8];
            2'b10: ld_byte = dmem_rdata[23:16];
            2'b11: ld_byte = dmem_rdata[31:24];
            default: ld_byte = dmem_rdata[7:0];
        endcase
        ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        we_d     = we_q;
        rd_d     = rd_q;
        f3_d     = f3_q;
        rw_d     = rw_q;
        load_d   = load_q;
        valid_d  = 1'b0;
        rw_out_d = 1'b0;
        fault_d  = 1'b0;
        wb_d     = wb_q;
        rd_out_d = rd_out_q;
        stall_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (!is_mem) begin
                        valid_d  = 1'b1;
                        wb_d     = alu_result_in;
                        rd_out_d = Rd_in;
                        rw_out_d = reg_write_in;
                    end else if (fault_c) begin
                        valid_d  = 1'b1;
                        fault_d  = 1'b1;
                        wb_d     = alu_result_in;
                        rd_out_d = Rd_in;
                    end else begin
                        stall_c  = 1'b1;
                        state_d  = ACCESS;
                        cnt_d    = 8'd0;
                        addr_d   = alu_result_in;
                        wdata_d  = st_wdata;
                        be_d     = mem_write_in ? st_be : 4'b1111;
                        we_d     = mem_write_in;
                        rd_d     = Rd_in;
                        f3_d     = funct3_in;
                        rw_d     = reg_write_in;
                        load_d   = mem_read_in;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d  = IDLE;
                    we_d     = 1'b0;
                    valid_d  = 1'b1;
                    rd_out_d = rd_q;
                    wb_d     = load_q ? ld_data : addr_q;
                    rw_out_d = load_q & rw_q;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d  = IDLE;
                    we_d     = 1'b0;
                    valid_d  = 1'b1;
                    fault_d  = 1'b1;
                    rd_out_d = rd_q;
                    wb_d     = addr_q;
                end else begin
                    stall_c  = 1'b1;
                    cnt_d    = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            we_q     <= 1'b0;
            rd_q     <= 5'd0;
            f3_q     <= 3'd0;
            rw_q     <= 1'b0;
            load_q   <= 1'b0;
            valid_q  <= 1'b0;
            rw_out_q <= 1'b0;
            fault_q  <= 1'b0;
            wb_q     <= 32'h0;
            rd_out_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            f3_q     <= f3_d;
            rw_q     <= rw_d;
            load_q   <= load_d;
            valid_q  <= valid_d;
            rw_out_q <= rw_out_d;
            fault_q  <= fault_d;
            wb_q     <= wb_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign dmem_req      = (state_q == ACCESS);
    assign dmem_we       = we_q;
    assign dmem_addr     = {addr_q[31:2], 2'b00};
    assign dmem_wdata    = wdata_q;
    assign dmem_be       = be_q;
    assign stall_out     = stall_c & ~reset;
    assign valid_out     = valid_q;
    assign reg_write_out = rw_out_q;
    assign mem_fault_out = fault_q;
    assign wb_data_out   = wb_q;
    assign Rd_out        = rd_out_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM/WB results are queued as
// instructions are presented and compared when valid_out appears.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [4:0]  Rd_in;
    logic        mem_read_in, mem_write_in, reg_write_in;
    logic [2:0]  funct3_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_out, valid_out, reg_write_out, mem_fault_out;
    logic [31:0] wb_data_out;
    logic [4:0]  Rd_out;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in),
        .Rd_in(Rd_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in), .funct3_in(funct3_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall_out(stall_out), .valid_out(valid_out),
        .reg_write_out(reg_write_out), .mem_fault_out(mem_fault_out),
        .wb_data_out(wb_data_out), .Rd_out(Rd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rw;
        logic        fault;
        logic        chk_wb;
        int          t0;
        int          lat;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc   = 0;

    logic        req_seen;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic m_fault(input logic mr, input logic mw, input logic [2:0] f3,
                                     input logic [31:0] a);
        if (mr && mw) return 1'b1;
        if (mr) begin
            if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
            if (f3 == 3'b001 || f3 == 3'b101) return a[0];
            if (f3 == 3'b010) return a[1:0] != 2'b00;
            return 1'b1;
        end
        if (mw) begin
            if (f3 == 3'b000) return 1'b0;
            if (f3 == 3'b001) return a[0];
            if (f3 == 3'b010) return a[1:0] != 2'b00;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*a[1:0] +: 8];
        h = rd[16*a[1] +: 16];
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b100:  return 32'(b);
            3'b001:  return 32'($signed(h));
            3'b101:  return 32'(h);
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b000) return 4'b0001 << a[1:0];
        if (f3 == 3'b001) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3 == 3'b000) return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
        if (f3 == 3'b001) return {sd[15:0], sd[15:0]};
        return sd;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (valid_out === 1'b1) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_valid", 32'(valid_out), 32'd0);
            end else begin
                e = q_exp.pop_front();
                if (e.chk_wb) begin
                    chk("wb_data", wb_data_out, e.wb);
                    chk("rd_out", 32'(Rd_out), 32'(e.rd));
                end
                chk("reg_write", 32'(reg_write_out), 32'(e.rw));
                chk("mem_fault", 32'(mem_fault_out), 32'(e.fault));
                chk("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end else begin
            chk("bubble_ctl", {30'd0, reg_write_out, mem_fault_out}, 32'd0);
        end
    end

    task automatic idle_inputs();
        valid_in     = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        reg_write_in = 1'b0;
        dmem_ack     = 1'b0;
    endtask

    // Presents one instruction, holds it while stalled, acks after ack_after
    // wait cycles (negative: never) and checks the request it produced.
    task automatic run_instr(input logic mr, input logic mw, input logic rw,
                             input logic [2:0] f3, input logic [31:0] alu,
                             input logic [31:0] sd, input logic [4:0] rd,
                             input int ack_after, input logic [31:0] rdata);
        exp_t e;
        int   stalls, acc, guard, exp_stalls;
        logic st, flt, is_mem;
        flt    = m_fault(mr, mw, f3, alu);
        is_mem = mr | mw;
        valid_in = 1'b1; mem_read_in = mr; mem_write_in = mw; reg_write_in = rw;
        funct3_in = f3; alu_result_in = alu; store_data_in = sd; Rd_in = rd;
        dmem_rdata = rdata;
        e.rd = rd; e.t0 = cyc; e.chk_wb = 1'b1; e.fault = 1'b0;
        if (!is_mem) begin
            e.wb = alu; e.rw = rw; e.lat = 1; exp_stalls = 0;
        end else if (flt) begin
            e.wb = alu; e.rw = 1'b0; e.fault = 1'b1; e.lat = 1; exp_stalls = 0;
        end else if (ack_after < 0) begin
            e.wb = alu; e.rw = 1'b0; e.fault = 1'b1; e.chk_wb = 1'b0;
            e.lat = 2 + TO; exp_stalls = 1 + TO;
        end else begin
            e.wb = mr ? m_load(f3, alu, rdata) : alu;
            e.rw = mr & rw; e.lat = 2 + ack_after; exp_stalls = 1 + ack_after;
        end
        q_exp.push_back(e);
        stalls = 0; acc = 0; guard = 0; req_seen = 1'b0;
        forever begin
            dmem_ack = dmem_req && (ack_after >= 0) && (acc == ack_after);
            @(negedge clk);
            st = stall_out;
            if (st) stalls++;
            if (dmem_req && !req_seen) begin
                req_seen = 1'b1; obs_addr = dmem_addr; obs_be = dmem_be;
                obs_we = dmem_we; obs_wdata = dmem_wdata;
            end
            if (dmem_req) acc++;
            @(posedge clk); #1;
            if (!st) break;
            guard++;
            if (guard > 40) begin
                chk("stall_bound", 32'(guard), 32'd40);
                break;
            end
        end
        idle_inputs();
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        if (!is_mem || flt) begin
            chk("no_req", 32'(req_seen), 32'd0);
        end else begin
            chk("req_seen", 32'(req_seen), 32'd1);
            chk("dmem_addr", obs_addr, {alu[31:2], 2'b00});
            chk("dmem_we", 32'(obs_we), 32'(mw));
            if (mw) begin
                chk("dmem_be", 32'(obs_be), 32'(m_be(f3, alu)));
                chk("dmem_wdata", obs_wdata, m_wdata(f3, sd));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        reset = 1'b1;
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1;
        funct3_in = 3'b010; alu_result_in = 32'h100; store_data_in = 32'h0; Rd_in = 5'd1;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_rw_fault", {30'd0, reg_write_out, mem_fault_out}, 32'd0);
        chk("rst_wb", wb_data_out, 32'd0);
        chk("rst_rd", 32'(Rd_out), 32'd0);
        chk("rst_req_we_be", {26'd0, dmem_req, dmem_we, dmem_be}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // ADD, then a bubble
        run_instr(1'b0, 1'b0, 1'b1, 3'b000, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
        @(posedge clk); #1;
        // LB 0x103, ack on first ACCESS cycle
        run_instr(1'b1, 1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 5'd7, 0, 32'h80FF_0000);
        chk("lb_wb_direct", wb_data_out, 32'hFFFF_FF80);
        // SH 0x202, ack after 3 wait cycles
        run_instr(1'b0, 1'b1, 1'b1, 3'b001, 32'h202, 32'hAAAA_BEEF, 5'd8, 3, 32'h0);
        chk("sh_wb_direct", wb_data_out, 32'h202);
        // misaligned LW
        run_instr(1'b1, 1'b0, 1'b1, 3'b010, 32'h6, 32'h0, 5'd9, 0, 32'h0);
        // LW that never gets an ack, then a stray ack in IDLE
        run_instr(1'b1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 5'd10, -1, 32'h0);
        @(negedge clk);
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("late_ack_valid", 32'(valid_out), 32'd0);
        chk("late_ack_req", 32'(dmem_req), 32'd0);

        // reset during the second ACCESS cycle
        valid_in = 1'b1; mem_read_in = 1'b1; reg_write_in = 1'b1;
        funct3_in = 3'b010; alu_result_in = 32'h100; Rd_in = 5'd11; dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("acc2_req", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_acc_req", 32'(dmem_req), 32'd0);
        chk("rst_acc_valid", 32'(valid_out), 32'd0);
        chk("rst_acc_stall", 32'(stall_out), 32'd0);
        idle_inputs();
        reset = 1'b0;
        @(posedge clk); #1;
        run_instr(1'b0, 1'b0, 1'b1, 3'b000, 32'h5555, 32'h0, 5'd12, 0, 32'h0);

        // lane sweep for sub-word loads and stores
        for (int l = 0; l < 4; l++) begin
            r = $urandom;
            run_instr(1'b1, 1'b0, 1'b1, 3'b000, 32'h300 + l, 32'h0, 5'(l + 1), l % 3, r);
            run_instr(1'b1, 1'b0, 1'b1, 3'b100, 32'h300 + l, 32'h0, 5'(l + 2), 0, r);
            run_instr(1'b0, 1'b1, 1'b0, 3'b000, 32'h310 + l, $urandom, 5'(l + 3), 1, 32'h0);
        end
        for (int l = 0; l < 2; l++) begin
            r = $urandom | 32'h8000_8000;
            run_instr(1'b1, 1'b0, 1'b1, 3'b001, 32'h320 + 2 * l, 32'h0, 5'd20, 0, r);
            run_instr(1'b1, 1'b0, 1'b1, 3'b101, 32'h320 + 2 * l, 32'h0, 5'd21, 2, r);
            run_instr(1'b0, 1'b1, 1'b1, 3'b001, 32'h330 + 2 * l, $urandom, 5'd22, 0, 32'h0);
        end
        run_instr(1'b1, 1'b0, 1'b1, 3'b010, 32'h340, 32'h0, 5'd23, 4, $urandom);
        run_instr(1'b0, 1'b1, 1'b1, 3'b010, 32'h344, $urandom, 5'd24, 0, 32'h0);
        run_instr(1'b1, 1'b0, 1'b0, 3'b000, 32'h350, 32'h0, 5'd25, 0, 32'h0000_007F);

        // fault table
        run_instr(1'b1, 1'b0, 1'b1, 3'b001, 32'h401, 32'h0, 5'd26, 0, 32'h0);
        run_instr(1'b1, 1'b0, 1'b1, 3'b101, 32'h403, 32'h0, 5'd27, 0, 32'h0);
        run_instr(1'b0, 1'b1, 1'b0, 3'b010, 32'h402, 32'h1, 5'd28, 0, 32'h0);
        run_instr(1'b1, 1'b0, 1'b1, 3'b011, 32'h404, 32'h0, 5'd29, 0, 32'h0);
        run_instr(1'b1, 1'b0, 1'b1, 3'b110, 32'h408, 32'h0, 5'd30, 0, 32'h0);
        run_instr(1'b0, 1'b1, 1'b0, 3'b100, 32'h40C, 32'h2, 5'd31, 0, 32'h0);
        run_instr(1'b0, 1'b1, 1'b0, 3'b101, 32'h410, 32'h3, 5'd2, 0, 32'h0);
        run_instr(1'b1, 1'b1, 1'b1, 3'b010, 32'h414, 32'h4, 5'd3, 0, 32'h0);
        run_instr(1'b0, 1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0, 5'd4, 0, 32'h0);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(q_exp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
